// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types, state encodings and helpers for the pipeline control unit
package core_ctrl_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int INST_ADDR_W = 32;

   typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
   typedef logic [INST_ADDR_W-1:0] inst_addr_t;

   typedef enum logic [1:0] {
      CTRL_RUN       = 2'd0,
      CTRL_STALL_RAW = 2'd1,
      CTRL_STALL_BUS = 2'd2,
      CTRL_FLUSH     = 2'd3
   } ctrl_state_e;

   localparam logic HOLD_ENABLE  = 1'b1;
   localparam logic HOLD_DISABLE = 1'b0;

   // A source operand depends on an in-flight write only if it is really read and is not x0.
   function automatic logic src_match(input logic used, input reg_addr_t rs, input reg_addr_t rd);
      return used && (rs != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// rtl/core_ctrl_if.sv - hazard inputs and stage control outputs between the pipeline and its controller
interface core_ctrl_if;
   import core_ctrl_pkg::*;

   logic        id_valid;
   reg_addr_t   id_rs1;
   reg_addr_t   id_rs2;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic        id_reg_we;
   reg_addr_t   id_rd;
   logic        ex_jump_flag;
   inst_addr_t  ex_jump_addr;
   logic        bus_hold_req;

   logic        hold_pc;
   logic        hold_if_id;
   logic        hold_id_ex;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        jump_flag_out;
   inst_addr_t  jump_addr_out;
   logic [1:0]  ctrl_state;
   logic [31:0] stall_cnt;

   // Pipeline side: reports hazards, obeys stage controls.
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_reg_we, id_rd,
      output ex_jump_flag, ex_jump_addr, bus_hold_req,
      input  hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
      input  jump_flag_out, jump_addr_out, ctrl_state, stall_cnt
   );

   // Controller side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_reg_we, id_rd,
      input  ex_jump_flag, ex_jump_addr, bus_hold_req,
      output hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
      output jump_flag_out, jump_addr_out, ctrl_state, stall_cnt
   );

endinterface

// File: rtl/core_ctrl_scoreboard.sv
// rtl/core_ctrl_scoreboard.sv - in-flight register write tracker and RAW hazard detection
module core_ctrl_scoreboard
   import core_ctrl_pkg::*;
#(
   parameter int WB_LATENCY = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      shift_en_i,
   input  logic      load_valid_i,
   input  reg_addr_t load_rd_i,
   input  logic      id_valid_i,
   input  reg_addr_t id_rs1_i,
   input  reg_addr_t id_rs2_i,
   input  logic      id_rs1_used_i,
   input  logic      id_rs2_used_i,
   output logic      raw_hazard_o
);

   logic      valid_q [WB_LATENCY];
   reg_addr_t rd_q    [WB_LATENCY];

   // Age every in-flight write by one slot per advancing cycle; the oldest one reaches the register file and drops out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WB_LATENCY; i++) begin
            valid_q[i] <= 1'b0;
            rd_q[i]    <= '0;
         end
      end else if (shift_en_i) begin
         valid_q[0] <= load_valid_i;
         rd_q[0]    <= load_rd_i;
         for (int i = 1; i < WB_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            rd_q[i]    <= rd_q[i-1];
         end
      end
   end

   // Any pending write to a register the ID instruction reads is a hazard, since nothing is forwarded.
   always_comb begin
      raw_hazard_o = 1'b0;
      for (int i = 0; i < WB_LATENCY; i++) begin
         if (valid_q[i] && (src_match(id_rs1_used_i, id_rs1_i, rd_q[i]) ||
                            src_match(id_rs2_used_i, id_rs2_i, rd_q[i]))) begin
            raw_hazard_o = id_valid_i;
         end
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - per-cycle advance/hold/flush decision for the IF/ID/EX stages
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int WB_LATENCY   = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   core_ctrl_if.slave bus
);

   ctrl_state_e state_q, state_d;
   logic [1:0]  flush_cnt_q, flush_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic       raw_hazard;
   logic       hold_pc, hold_if_id, hold_id_ex;
   logic       flush_if_id, flush_id_ex;
   logic       jump_flag;
   inst_addr_t jump_addr;
   logic       issue;
   logic       sb_load;

   // Only an instruction that actually leaves ID this cycle becomes an in-flight write.
   assign issue   = !hold_id_ex && !flush_id_ex;
   assign sb_load = bus.id_valid && bus.id_reg_we && (bus.id_rd != '0) && issue;

   core_ctrl_scoreboard #(
      .WB_LATENCY (WB_LATENCY)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .shift_en_i    (!bus.bus_hold_req),
      .load_valid_i  (sb_load),
      .load_rd_i     (bus.id_rd),
      .id_valid_i    (bus.id_valid),
      .id_rs1_i      (bus.id_rs1),
      .id_rs2_i      (bus.id_rs2),
      .id_rs1_used_i (bus.id_rs1_used),
      .id_rs2_used_i (bus.id_rs2_used),
      .raw_hazard_o  (raw_hazard)
   );

   // Prioritised decision: bus wait freezes everything and defers a jump; a jump beats the wrong-path hazard.
   always_comb begin
      state_d     = CTRL_RUN;
      flush_cnt_d = flush_cnt_q;
      hold_pc     = HOLD_DISABLE;
      hold_if_id  = HOLD_DISABLE;
      hold_id_ex  = HOLD_DISABLE;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_flag   = 1'b0;
      jump_addr   = '0;
      if (bus.bus_hold_req) begin
         state_d    = CTRL_STALL_BUS;
         hold_pc    = HOLD_ENABLE;
         hold_if_id = HOLD_ENABLE;
         hold_id_ex = HOLD_ENABLE;
      end else if (bus.ex_jump_flag) begin
         state_d     = CTRL_FLUSH;
         jump_flag   = 1'b1;
         jump_addr   = bus.ex_jump_addr;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
         flush_cnt_d = 2'(FLUSH_CYCLES - 1);
      end else if (flush_cnt_q != 2'd0) begin
         state_d     = CTRL_FLUSH;
         flush_if_id = 1'b1;
         flush_cnt_d = flush_cnt_q - 2'd1;
      end else if (raw_hazard) begin
         state_d     = CTRL_STALL_RAW;
         hold_pc     = HOLD_ENABLE;
         hold_if_id  = HOLD_ENABLE;
         flush_id_ex = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Record this cycle's decision, the remaining flush cycles and the stall count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CTRL_RUN;
         flush_cnt_q <= 2'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.hold_pc       = hold_pc;
   assign bus.hold_if_id    = hold_if_id;
   assign bus.hold_id_ex    = hold_id_ex;
   assign bus.flush_if_id   = flush_if_id;
   assign bus.flush_id_ex   = flush_id_ex;
   assign bus.jump_flag_out = jump_flag;
   assign bus.jump_addr_out = jump_addr;
   assign bus.ctrl_state    = state_q;
   assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed vectors plus randomized model comparison for core_ctrl
module tb_core_ctrl;

   localparam int WB_LAT = 2;
   localparam int FL_CYC = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   core_ctrl_if bus_if ();

   core_ctrl #(
      .WB_LATENCY   (WB_LAT),
      .FLUSH_CYCLES (FL_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic        we;
      logic [4:0]  rd;
      logic        jf;
      logic [31:0] ja;
      logic        bh;
      logic [5:0]  ctl;
      logic [31:0] ea;
      logic [1:0]  st;
      logic [31:0] sc;
   } vec_t;

   int passed = 0;
   int total  = 0;

   function automatic vec_t row(input logic r, input logic iv, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic we, input logic [4:0] rd,
                                input logic jf, input logic [31:0] ja, input logic bh,
                                input logic [5:0] ctl, input logic [31:0] ea, input logic [1:0] st,
                                input logic [31:0] sc);
      vec_t v;
      v.rst = r; v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.we = we; v.rd = rd;
      v.jf = jf; v.ja = ja; v.bh = bh; v.ctl = ctl; v.ea = ea; v.st = st; v.sc = sc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [5:0] dut_ctl();
      return {bus_if.hold_pc, bus_if.hold_if_id, bus_if.hold_id_ex,
              bus_if.flush_if_id, bus_if.flush_id_ex, bus_if.jump_flag_out};
   endfunction

   task automatic drive(input vec_t v);
      rst                 = v.rst;
      bus_if.id_valid     = v.iv;
      bus_if.id_rs1       = v.rs1;
      bus_if.id_rs1_used  = v.u1;
      bus_if.id_rs2       = v.rs2;
      bus_if.id_rs2_used  = v.u2;
      bus_if.id_reg_we    = v.we;
      bus_if.id_rd        = v.rd;
      bus_if.ex_jump_flag = v.jf;
      bus_if.ex_jump_addr = v.ja;
      bus_if.bus_hold_req = v.bh;
   endtask

   // One cycle: drive after the edge, compare mid-cycle, advance to just past the next edge.
   task automatic apply(input vec_t v, input string tag);
      drive(v);
      @(negedge clk);
      if (!v.rst) begin
         check({tag, ".ctl"},   32'(dut_ctl()),         32'(v.ctl));
         check({tag, ".jaddr"}, bus_if.jump_addr_out,   v.ea);
         check({tag, ".state"}, 32'(bus_if.ctrl_state), 32'(v.st));
         check({tag, ".stall"}, bus_if.stall_cnt,       v.sc);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [21];

   // Reference model state: pending writes as (register, cycles until written).
   logic [4:0] pend_rd   [$];
   int         pend_left [$];
   int         m_flush;
   int         m_prev;
   logic [31:0] m_stall;

   initial begin
      vec_t idle;
      idle = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      drive(idle);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset.ctl",   32'(dut_ctl()),         32'd0);
      check("reset.jaddr", bus_if.jump_addr_out,   32'd0);
      check("reset.state", 32'(bus_if.ctrl_state), 32'd0);
      check("reset.stall", bus_if.stall_cnt,       32'd0);
      @(posedge clk);
      #1;

      //              rst iv rs1 u1 rs2 u2 we rd jf ja         bh ctl        ea         st sc
      tbl[0]  = row(0, 1, 0, 0, 0, 0, 1, 5, 0, 0,         0, 6'b000000, 0,         0, 0);  // write x5
      tbl[1]  = row(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,         0, 6'b110010, 0,         0, 0);  // read x5: stall
      tbl[2]  = row(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,         0, 6'b110010, 0,         1, 1);
      tbl[3]  = row(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         1, 2);  // written, issues
      tbl[4]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         0, 2);
      tbl[5]  = row(0, 1, 0, 0, 0, 0, 1, 0, 0, 0,         0, 6'b000000, 0,         0, 2);  // write x0
      tbl[6]  = row(0, 1, 0, 1, 0, 1, 0, 0, 0, 0,         0, 6'b000000, 0,         0, 2);  // read x0: no stall
      tbl[7]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         0, 2);
      tbl[8]  = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100,   0, 6'b000111, 32'h100,   0, 2);  // jump
      tbl[9]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000100, 0,         3, 2);
      tbl[10] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         3, 2);
      tbl[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         0, 2);
      tbl[12] = row(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,         0, 6'b000000, 0,         0, 2);  // write x7
      tbl[13] = row(0, 1, 7, 1, 0, 0, 0, 0, 1, 32'h200,   0, 6'b000111, 32'h200,   0, 2);  // hazard + jump
      tbl[14] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000100, 0,         3, 2);
      tbl[15] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         3, 2);
      tbl[16] = row(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,         0, 6'b000000, 0,         0, 2);  // x7 written
      tbl[17] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300,   0, 6'b000111, 32'h300,   0, 2);
      tbl[18] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h304,   0, 6'b000111, 32'h304,   3, 2);  // restart
      tbl[19] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000100, 0,         3, 2);
      tbl[20] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 6'b000000, 0,         3, 2);
      for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("row%0d", i));

      // Bus hold freezes the scoreboard: x9 still pending for two cycles after release.
      apply(row(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6'b000000, 0, 0, 2), "bus.w9");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b111000, 0, 0, 2), "bus.h1");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b111000, 0, 2, 3), "bus.h2");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b111000, 0, 2, 4), "bus.h3");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 0, 2, 5), "bus.r1");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 0, 1, 6), "bus.r2");
      apply(row(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 7), "bus.r3");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 7), "bus.idle");

      // Jump deferred under bus hold, taken in the release cycle.
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 6'b111000, 0,       0, 7),  "defer.h1");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 6'b111000, 0,       2, 8),  "defer.h2");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 6'b111000, 0,       2, 9),  "defer.h3");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 6'b000111, 32'h400, 2, 10), "defer.go");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 6'b000100, 0,       3, 10), "defer.fl");

      // Reset mid-flush with x12 pending: everything clears.
      apply(row(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h500, 0, 6'b000111, 32'h500, 3, 10), "rstfl.j");
      apply(row(0, 1, 0, 0, 0, 0, 1, 12, 0, 0,       0, 6'b000100, 0,       3, 10), "rstfl.w12");
      apply(row(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,       0, 6'b000000, 0,       0, 0),  "rstfl.rst");
      apply(row(0, 1, 0, 0, 12, 1, 0, 0, 0, 0,       0, 6'b000000, 0,       0, 0),  "rstfl.r12");
      apply(row(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,       0, 6'b000000, 0,       0, 0),  "rstfl.idle");

      // Randomized traffic against a pending-write list model.
      drive(idle);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pend_rd.delete();
      pend_left.delete();
      m_flush = 0;
      m_prev  = 0;
      m_stall = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         vec_t v;
         logic haz;
         logic issued;
         int   dec;
         v = idle;
         v.iv  = ($urandom_range(0, 99) < 80);
         v.rs1 = 5'($urandom_range(0, 3));
         v.rs2 = 5'($urandom_range(0, 3));
         v.u1  = 1'($urandom_range(0, 1));
         v.u2  = 1'($urandom_range(0, 1));
         v.we  = 1'($urandom_range(0, 1));
         v.rd  = 5'($urandom_range(0, 3));
         v.jf  = ($urandom_range(0, 99) < 10);
         v.ja  = $urandom();
         v.bh  = ($urandom_range(0, 99) < 12);

         haz = 1'b0;
         for (int k = 0; k < pend_rd.size(); k++) begin
            if ((v.u1 && v.rs1 != 0 && v.rs1 == pend_rd[k]) ||
                (v.u2 && v.rs2 != 0 && v.rs2 == pend_rd[k])) haz = v.iv;
         end

         v.ea = 0;
         if (v.bh) begin
            dec = 2; v.ctl = 6'b111000;
         end else if (v.jf) begin
            dec = 3; v.ctl = 6'b000111; v.ea = v.ja; m_flush = FL_CYC - 1;
         end else if (m_flush > 0) begin
            dec = 3; v.ctl = 6'b000100; m_flush--;
         end else if (haz) begin
            dec = 1; v.ctl = 6'b110010;
         end else begin
            dec = 0; v.ctl = 6'b000000;
         end
         v.st = 2'(m_prev);
         v.sc = m_stall;
         apply(v, $sformatf("rand%0d", cyc));

         issued = !v.ctl[3] && !v.ctl[1];
         if (!v.bh) begin
            for (int k = pend_left.size() - 1; k >= 0; k--) begin
               pend_left[k]--;
               if (pend_left[k] <= 0) begin
                  pend_left.delete(k);
                  pend_rd.delete(k);
               end
            end
            if (issued && v.iv && v.we && v.rd != 0) begin
               pend_rd.push_back(v.rd);
               pend_left.push_back(WB_LAT);
            end
         end
         if (v.ctl[5] && m_stall != 32'hFFFF_FFFF) m_stall++;
         m_prev = dec;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
